// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_UMULL = 3'b001,
    OP_SMULL = 3'b010,
    OP_UDIV  = 3'b100,
    OP_SDIV  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_UDIV) || (op == OP_SDIV);
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL) || is_div(op);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the controller (master) and the mul/div unit (slave).
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;
  logic             div_zero;
  logic [1:0]       state;

  modport master (output start, op, a, b,
                  input  busy, done, result_lo, result_hi, flag_n, flag_z, div_zero, state);
  modport slave  (input  start, op, a, b,
                  output busy, done, result_lo, result_hi, flag_n, flag_z, div_zero, state);
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Accumulator layout is {high half, low half}; the low half carries the
// multiplier bits (consumed from the LSB) or the dividend/quotient bits.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;

  // Next accumulator for the selected mode
  always_comb begin
    sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem  = acc_i[2*WIDTH-1:WIDTH-1];
    // remainder before subtract is < 2*divisor, so the difference fits WIDTH bits
    diff = rem[WIDTH-1:0] - opnd_i;
    if (div_i) begin
      if (rem >= {1'b0, opnd_i}) acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
      else                       acc_o = {rem[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative multicycle multiply/divide unit: MUL, UMULL, SMULL, UDIV, SDIV
// with NZ flags. Works on magnitudes and applies signs in a single fixup cycle.
import mdu_pkg::*;

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int CNTW = $clog2(WIDTH+1);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic               fn_q, fn_d, fz_q, fz_d, dzo_q, dzo_d;
  logic [WIDTH-1:0]   fix_lo, fix_hi, a_mag, b_mag;
  logic               fix_n, fix_z, is_long, sgn_op, a_neg, b_neg, b_zero;

  // Operand conditioning of the incoming request
  assign sgn_op = (bus.op == OP_SMULL) || (bus.op == OP_SDIV);
  assign a_neg  = sgn_op & bus.a[WIDTH-1];
  assign b_neg  = sgn_op & bus.b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;
  assign b_zero = (bus.b == '0);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div(op_q)),
    .acc_o  (acc_step)
  );

  // Sign fixup and flag generation from the finished magnitude result
  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    is_long = (op_q == OP_UMULL) || (op_q == OP_SMULL);
    if (is_div(op_q)) begin
      fix_lo = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      fix_hi = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo = prod[WIDTH-1:0];
      fix_hi = (op_q == OP_MUL) ? '0 : prod[2*WIDTH-1:WIDTH];
    end
    fix_n = is_long ? fix_hi[WIDTH-1] : fix_lo[WIDTH-1];
    fix_z = is_long ? ~|{fix_hi, fix_lo} : ~|fix_lo;
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    fn_d      = fn_q;
    fz_d      = fz_q;
    dzo_d     = dzo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start && op_valid(bus.op)) begin
          op_d   = bus.op;
          opnd_d = b_mag;
          cnt_d  = CNTW'(WIDTH);
          if (is_div(bus.op) && b_zero) begin
            // raw dividend lands in the remainder half; no sign fixup applies
            acc_d     = {bus.a, {WIDTH{1'b0}}};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            dz_d      = 1'b1;
            state_d   = S_FIXUP;
          end else begin
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg & is_div(bus.op);
            dz_d      = 1'b0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        res_lo_d = fix_lo;
        res_hi_d = fix_hi;
        fn_d     = fix_n;
        fz_d     = fix_z;
        dzo_d    = dz_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      fn_q      <= 1'b0;
      fz_q      <= 1'b0;
      dzo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      fn_q      <= fn_d;
      fz_q      <= fz_d;
      dzo_q     <= dzo_d;
    end
  end

  assign bus.busy      = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign bus.done      = (state_q == S_DONE);
  assign bus.state     = state_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.flag_n    = fn_q;
  assign bus.flag_z    = fz_q;
  assign bus.div_zero  = dzo_q;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multicycle multiply/divide unit. Generalises the fixed 32-bit MUL/long-multiply path of the multicycle ARM core.
- Parametrised operand width. Adds UMULL, SMULL, UDIV and SDIV plus NZ flag generation.
- Sits beside the ALU in the datapath. The controller issues a start pulse and stalls on busy; the result is written through ResultSrc when done is asserted.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 8.
CNTW, $clog2(WIDTH+1), iteration counter width (derived, do not override).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE or DONE
op  input  3  operation: 000 MUL, 001 UMULL, 010 SMULL, 100 UDIV, 101 SDIV, others reserved
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high in CALC and FIXUP
done  output  1  one-cycle pulse in DONE
result_lo  output  WIDTH  product low half / quotient
result_hi  output  WIDTH  product high half / remainder (0 for MUL)
flag_n  output  1  MSB of the full result (result_hi MSB for long ops, result_lo MSB otherwise)
flag_z  output  1  full result equals zero (both halves for long ops)
div_zero  output  1  last divide had b==0
state  output  2  FSM state for debug display: 0 IDLE, 1 CALC, 2 FIXUP, 3 DONE

Behaviour:
- Reset (reset==0, async): FSM=IDLE; counter, operand registers and all outputs = 0. Reset mid-operation aborts with no done pulse.
- IDLE: start=1 starts an operation.
  - Latch op and operand magnitudes. Signed ops latch |a|, |b| and record the result signs.
  - Clear the accumulator, load counter=WIDTH, go to CALC.
  - Reserved op: ignored, stay in IDLE.
- CALC: one radix-2 step per cycle, decrement counter, go to FIXUP after WIDTH steps.
  - Multiply: shift-add over the 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient in the low half, remainder in the high half.
- Divide by zero: skip CALC; go IDLE->FIXUP directly. Result: result_lo=0, result_hi=a, div_zero=1.
- FIXUP (1 cycle):
  - Two's-complement negate the product if sign(a)^sign(b) for SMULL.
  - SDIV: negate the quotient if the signs differ; negate the remainder if a<0 (truncating division; remainder takes the dividend's sign).
  - SDIV of most-negative / -1: result_lo = most-negative, no trap.
  - Register result_lo, result_hi, flag_n, flag_z, div_zero. MUL forces result_hi=0.
- DONE (1 cycle): done=1, busy=0.
  - start=1 here is accepted as a new operation (back-to-back issue, goes to CALC).
  - Otherwise go to IDLE.
- Latency: start sampled at edge t -> done high during cycle t+WIDTH+2. Divide by zero: done during cycle t+2.
- Result outputs and flags hold their value until the next FIXUP or reset.
- start in CALC/FIXUP is ignored; no queuing.
- Inputs a, b and op may change after the start edge; only the latched copies are used.
- Simultaneous start and async reset: reset wins.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings: OP_MUL, OP_UMULL, OP_SMULL, OP_UDIV, OP_SDIV
  - state encodings: S_IDLE, S_CALC, S_FIXUP, S_DONE
  - an is_div(op) helper
- One sub-module, mdu_step: combinational single iteration. Inputs: accumulator, operand, mode. Output: next accumulator. Keeps the FSM and width logic in mul_div_unit.

Test Plan:
- MUL a=7, b=6 -> done at start+34 cycles; result_lo=0x0000002A, result_hi=0, flag_n=0, flag_z=0.
- SMULL a=0xFFFFFFFD (-3), b=5 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1, flag_n=1. UMULL a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001.
- SDIV a=0xFFFFFFF9 (-7), b=2 -> result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF. SDIV a=0x80000000, b=0xFFFFFFFF -> result_lo=0x80000000.
- UDIV a=100, b=0 -> done at start+2; result_lo=0, result_hi=100, div_zero=1. Next UDIV 100/7 -> result_lo=14, result_hi=2, div_zero=0.
- MUL 0*5 -> flag_z=1. Then pulse start with op=UMULL during CALC of a MUL -> ignored, single done, MUL result returned.
- Assert reset at cycle 10 of CALC -> all outputs 0, state=IDLE, no done. Back-to-back start in DONE -> second done exactly WIDTH+2 cycles later.
